credential_entry: RTL
=====================

Name: credential_entry

Overview:
- Operator-side front end feeding the unlocker.
- Collects keypad digits from switches plus an enter button into a 4-digit username field and a 4-digit password field. Drives inputCount to the unlocker.
- Obeys the unlocker's resetCount clear request.
- Closes the error-flag handshake: holds off entry for an error or lockout period, then asserts flagResolve.

Parameters:
- ERR_CYCLES, 100_000_000, entry hold-off after a single failed attempt (flagSelect=0).
- LOCKOUT_CYCLES, 1_000_000_000, entry hold-off after the third failed attempt (flagSelect=1).
- CNT_W, 32, width of the hold-off timer; must hold max(ERR_CYCLES, LOCKOUT_CYCLES).

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- digit_in  in  4  digit value from the switches
- btn_enter  in  1  debounced single-cycle pulse; append digit_in
- btn_back  in  1  debounced single-cycle pulse; delete last digit
- resetCount  in  1  clear request from the unlocker (level; rising edge acts)
- flag  in  1  error flag from the unlocker
- flagSelect  in  1  0 = wrong password, 1 = third failure
- inputCount  out  4  number of digits held, 0..8
- userNameInput0..3  out  4 each  username digits; digit 0 entered first
- passwordInput0..3  out  4 each  password digits; digit 0 entered first
- flagResolve  out  1  handshake back to the unlocker
- busy  out  1  high in any flag state; entry ignored
- lockout  out  1  high only in LOCKOUT
- disp_digit  out  4  last accepted digit, for the 7-segment display

Behaviour:
- Reset: all digit outputs 0, inputCount 0, flagResolve 0, busy 0, lockout 0, disp_digit 0, state ENTRY, resetCount edge register 0. Reset mid-operation aborts any hold-off immediately.
- Slot map: inputCount 0..3 writes userNameInput[count]; inputCount 4..7 writes passwordInput[count-4].
- ENTRY, btn_enter, count<8: store digit_in in the slot, increment count, set disp_digit. All register outputs update next edge (1-cycle latency).
- btn_enter at count==8: ignored, no wrap.
- btn_back with count>0: decrement count and zero the vacated slot. At count==0: ignored.
- btn_enter and btn_back in the same cycle: both ignored.
- resetCount rising edge (registered previous value is 0, current is 1): zero all 8 digits and count on the next edge. Holding resetCount high does not block further entry.
- Clear request in the same cycle as btn_enter or btn_back: clear wins, button dropped.
- flag high in ENTRY: next edge zeroes all digits and count, loads the timer, and goes to ERR (flagSelect=0, timer=ERR_CYCLES-1) or LOCKOUT (flagSelect=1, timer=LOCKOUT_CYCLES-1).
- flag has priority over buttons and resetCount in the same cycle.
- ERR/LOCKOUT: busy=1, lockout=1 in LOCKOUT only. Buttons and resetCount are ignored. Timer decrements each cycle; at 0, go to RESOLVE.
- RESOLVE: flagResolve=1, busy=1. Hold until flag is sampled low, then go to ENTRY with flagResolve=0 on that edge.
- If flag drops before the timer expires (unlocker reset): go straight to ENTRY and abandon the timer.
- State sequence: ENTRY -> ERR|LOCKOUT -> RESOLVE -> ENTRY.

Optional Feature:
- Macro: CRED_MASK_EN.
- Defined: when the accepted digit goes into a password slot, disp_digit shows 4'hF instead of the value. Username digits display normally.
- Undefined: disp_digit always shows the true value.
- Digit outputs to the unlocker are unaffected either way.

Decomposition:
- Shared package cred_pkg holds:
  - state enum {ENTRY, ERR, LOCKOUT, RESOLVE}
  - DIGIT_W=4, USER_DIGITS=4, MAX_DIGITS=8
  - MASK_GLYPH=4'hF
- Sub-module cred_holdoff_timer: loadable down-counter (load, value, done) of CNT_W bits, instantiated once.

Test Plan (ERR_CYCLES=4, LOCKOUT_CYCLES=10):
- Reset, then enter 1,1,0,0,1,1,0,0 -> userNameInput3..0=0,0,1,1; passwordInput3..0=0,0,1,1; inputCount=8. A 9th enter leaves all outputs unchanged.
- Enter 5,6,7, btn_back, enter 9 -> inputCount=3, userNameInput2=9; vacated slot was zero before the rewrite.
- Fill to 8, pulse resetCount high and hold it -> all digits 0, count 0. A subsequent enter of 3 succeeds with count=1 while resetCount is still high.
- flag=1, flagSelect=0 -> busy=1 and entry ignored for 4 cycles, then flagResolve=1. Drop flag -> flagResolve=0, busy=0 next edge.
- flag=1, flagSelect=1 -> lockout=1 for 10 cycles, then flagResolve. Assert rst at cycle 5 -> all outputs 0 and state ENTRY immediately.
- CRED_MASK_EN defined: enter 4 digits then 7 -> disp_digit=F. Without the macro -> disp_digit=7.

Source files
------------

// File: rtl/cred_pkg.sv
// Shared types and sizing for the credential entry front end.
package cred_pkg;

    typedef enum logic [1:0] {
        ENTRY   = 2'd0,
        ERR     = 2'd1,
        LOCKOUT = 2'd2,
        RESOLVE = 2'd3
    } state_t;

    localparam int DIGIT_W     = 4;
    localparam int USER_DIGITS = 4;
    localparam int MAX_DIGITS  = 8;

    localparam logic [DIGIT_W-1:0] MASK_GLYPH = 4'hF;

endpackage

// File: rtl/cred_holdoff_timer.sv
// Loadable down-counter; done is high while the count sits at zero.
module cred_holdoff_timer #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] value,
    output logic             done
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= value;
        end else if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    assign done = (cnt == '0);

endmodule

// File: rtl/credential_entry.sv
// Keypad front end for the unlocker: username/password digit capture plus error hold-off handshake.
// Build option: define CRED_MASK_EN to show MASK_GLYPH on the display for password digits.
module credential_entry
    import cred_pkg::*;
#(
    parameter int unsigned ERR_CYCLES     = 100_000_000,
    parameter int unsigned LOCKOUT_CYCLES = 1_000_000_000,
    parameter int          CNT_W          = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [DIGIT_W-1:0] digit_in,
    input  logic               btn_enter,
    input  logic               btn_back,
    input  logic               resetCount,
    input  logic               flag,
    input  logic               flagSelect,
    output logic [3:0]         inputCount,
    output logic [DIGIT_W-1:0] userNameInput0,
    output logic [DIGIT_W-1:0] userNameInput1,
    output logic [DIGIT_W-1:0] userNameInput2,
    output logic [DIGIT_W-1:0] userNameInput3,
    output logic [DIGIT_W-1:0] passwordInput0,
    output logic [DIGIT_W-1:0] passwordInput1,
    output logic [DIGIT_W-1:0] passwordInput2,
    output logic [DIGIT_W-1:0] passwordInput3,
    output logic               flagResolve,
    output logic               busy,
    output logic               lockout,
    output logic [DIGIT_W-1:0] disp_digit
);

    localparam logic [CNT_W-1:0] ERR_LOAD  = CNT_W'(ERR_CYCLES - 1);
    localparam logic [CNT_W-1:0] LOCK_LOAD = CNT_W'(LOCKOUT_CYCLES - 1);
    localparam logic [3:0]       CNT_MAX   = 4'(MAX_DIGITS);

    state_t             state;
    logic [DIGIT_W-1:0] digits [MAX_DIGITS];
    logic [3:0]         count;
    logic               reset_count_p1;

    logic               clear_req;
    logic               enter_ok;
    logic               back_ok;
    logic               tmr_load;
    logic [CNT_W-1:0]   tmr_value;
    logic               tmr_done;

    assign clear_req = resetCount & ~reset_count_p1;
    assign enter_ok  = btn_enter & ~btn_back & (count < CNT_MAX);
    assign back_ok   = btn_back & ~btn_enter & (count != 4'd0);
    assign tmr_load  = (state == ENTRY) & flag;
    assign tmr_value = flagSelect ? LOCK_LOAD : ERR_LOAD;

    cred_holdoff_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk   (clk),
        .rst   (rst),
        .load  (tmr_load),
        .value (tmr_value),
        .done  (tmr_done)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= ENTRY;
            count          <= 4'd0;
            reset_count_p1 <= 1'b0;
            flagResolve    <= 1'b0;
            busy           <= 1'b0;
            lockout        <= 1'b0;
            disp_digit     <= '0;
            for (int i = 0; i < MAX_DIGITS; i++) digits[i] <= '0;
        end else begin
            reset_count_p1 <= resetCount;
            case (state)
                ENTRY: begin
                    // Priority: unlocker flag, then clear request, then keypad buttons.
                    if (flag) begin
                        count   <= 4'd0;
                        for (int i = 0; i < MAX_DIGITS; i++) digits[i] <= '0;
                        state   <= flagSelect ? LOCKOUT : ERR;
                        busy    <= 1'b1;
                        lockout <= flagSelect;
                    end else if (clear_req) begin
                        count <= 4'd0;
                        for (int i = 0; i < MAX_DIGITS; i++) digits[i] <= '0;
                    end else if (enter_ok) begin
                        digits[count[2:0]] <= digit_in;
                        count              <= count + 4'd1;
`ifdef CRED_MASK_EN
                        disp_digit <= (count >= 4'(USER_DIGITS)) ? MASK_GLYPH : digit_in;
`else
                        disp_digit <= digit_in;
`endif
                    end else if (back_ok) begin
                        digits[3'(count - 4'd1)] <= '0;
                        count                    <= count - 4'd1;
                    end
                end
                ERR, LOCKOUT: begin
                    // A dropped flag means the unlocker was reset; abandon the hold-off.
                    if (!flag) begin
                        state   <= ENTRY;
                        busy    <= 1'b0;
                        lockout <= 1'b0;
                    end else if (tmr_done) begin
                        state       <= RESOLVE;
                        lockout     <= 1'b0;
                        flagResolve <= 1'b1;
                    end
                end
                RESOLVE: begin
                    if (!flag) begin
                        state       <= ENTRY;
                        busy        <= 1'b0;
                        flagResolve <= 1'b0;
                    end
                end
                default: begin
                    state       <= ENTRY;
                    busy        <= 1'b0;
                    lockout     <= 1'b0;
                    flagResolve <= 1'b0;
                end
            endcase
        end
    end

    assign inputCount     = count;
    assign userNameInput0 = digits[0];
    assign userNameInput1 = digits[1];
    assign userNameInput2 = digits[2];
    assign userNameInput3 = digits[3];
    assign passwordInput0 = digits[USER_DIGITS + 0];
    assign passwordInput1 = digits[USER_DIGITS + 1];
    assign passwordInput2 = digits[USER_DIGITS + 2];
    assign passwordInput3 = digits[USER_DIGITS + 3];

endmodule
